mips_decode_execute: RTL and testbench

Decode-and-execute slice for the five-stage MIPS pipeline. Decodes the instruction opcode into main control signals, derives the 4-bit ALU control code from ALU-op plus funct, selects the second operand, and evaluates the ALU. All outputs are captured in a single output register that plays the role of the EX/MEM boundary for control and ALU data.

---
 rtl/mips_decode_execute.sv | 187 ++++++++++++++++++
 tb/tb_mips_decode_execute.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_decode_execute.sv
// mips_decode_execute
// Decode-and-execute slice of the five-stage MIPS pipeline. The opcode is
// decoded into main control, ALU-op plus funct select a 4-bit ALU control
// code, operand B is chosen between rt_data and the sign-extended immediate,
// and the ALU is evaluated. Everything is captured in one output register
// that acts as the EX/MEM boundary for control and ALU data (1-cycle latency,
// no combinational input-to-output path).
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous active-high reset, clears all outputs
//   bubble    in   1   clears all outputs this cycle (stall/flush)
//   instr     in  32   instruction (opcode [31:26], funct [5:0], imm [15:0])
//   rs_data   in  32   ALU operand A (already forwarded)
//   rt_data   in  32   register operand B (already forwarded)
//   regdst, alusrc, memread, memwrite, memtoreg, regwrite   out 1 each
//   branch    out  2   bit0 = BEQ, bit1 = BNE
//   aluop     out  2   ALU-op
//   aluctl    out  4   ALU control code
//   result    out 32   ALU result
//   zero      out  1   result == 0
//   overflow  out  1   signed overflow for add/sub, 0 otherwise
module mips_decode_execute (
   input  logic        clk,
   input  logic        rst,
   input  logic        bubble,
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        regdst,
   output logic        alusrc,
   output logic        memread,
   output logic        memwrite,
   output logic        memtoreg,
   output logic        regwrite,
   output logic [1:0]  branch,
   output logic [1:0]  aluop,
   output logic [3:0]  aluctl,
   output logic [31:0] result,
   output logic        zero,
   output logic        overflow
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_XOR = 4'b1101;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        c_regdst, c_alusrc, c_memread, c_memwrite, c_memtoreg, c_regwrite;
   logic [1:0]  c_branch, c_aluop;
   logic [3:0]  c_aluctl;
   logic [31:0] op_a, op_b;
   logic [31:0] sum, diff, c_result;
   logic        c_overflow;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];

   // Main control; unknown opcodes fall through to all-zero (NOP).
   always_comb begin
      c_regdst   = 1'b0;
      c_alusrc   = 1'b0;
      c_memtoreg = 1'b0;
      c_regwrite = 1'b0;
      c_memread  = 1'b0;
      c_memwrite = 1'b0;
      c_branch   = 2'b00;
      c_aluop    = 2'b00;
      case (opcode)
         6'b000000: begin  // R-type
            c_regdst   = 1'b1;
            c_regwrite = 1'b1;
            c_aluop    = 2'b10;
         end
         6'b100011: begin  // lw
            c_alusrc   = 1'b1;
            c_memtoreg = 1'b1;
            c_regwrite = 1'b1;
            c_memread  = 1'b1;
         end
         6'b101011: begin  // sw
            c_alusrc   = 1'b1;
            c_memwrite = 1'b1;
         end
         6'b000100: begin  // beq
            c_branch = 2'b01;
            c_aluop  = 2'b01;
         end
         6'b000101: begin  // bne
            c_branch = 2'b10;
            c_aluop  = 2'b01;
         end
         6'b001000: begin  // addi
            c_alusrc   = 1'b1;
            c_regwrite = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU control from ALU-op and funct.
   always_comb begin
      c_aluctl = ALU_ADD;
      case (c_aluop)
         2'b01: c_aluctl = ALU_SUB;
         2'b10: begin
            case (funct)
               6'b100000: c_aluctl = ALU_ADD;
               6'b100010: c_aluctl = ALU_SUB;
               6'b100100: c_aluctl = ALU_AND;
               6'b100101: c_aluctl = ALU_OR;
               6'b100110: c_aluctl = ALU_XOR;
               6'b100111: c_aluctl = ALU_NOR;
               6'b101010: c_aluctl = ALU_SLT;
               default:   c_aluctl = ALU_ADD;
            endcase
         end
         default: c_aluctl = ALU_ADD;
      endcase
   end

   assign op_a = rs_data;
   assign op_b = c_alusrc ? {{16{instr[15]}}, instr[15:0]} : rt_data;
   assign sum  = op_a + op_b;
   assign diff = op_a - op_b;

   // ALU. Overflow is only defined for add and sub; it is derived from the
   // operand and result sign bits.
   always_comb begin
      c_result   = 32'd0;
      c_overflow = 1'b0;
      case (c_aluctl)
         ALU_ADD: begin
            c_result   = sum;
            c_overflow = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
         end
         ALU_SUB: begin
            c_result   = diff;
            c_overflow = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
         end
         ALU_AND: c_result = op_a & op_b;
         ALU_OR:  c_result = op_a | op_b;
         ALU_XOR: c_result = op_a ^ op_b;
         ALU_NOR: c_result = ~(op_a | op_b);
         ALU_SLT: c_result = {31'd0, $signed(op_a) < $signed(op_b)};
         default: c_result = 32'd0;
      endcase
   end

   // Output register. Reset and bubble load the same all-zero word, so zero
   // is 0 after either even though result is also 0.
   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         regdst   <= 1'b0;
         alusrc   <= 1'b0;
         memread  <= 1'b0;
         memwrite <= 1'b0;
         memtoreg <= 1'b0;
         regwrite <= 1'b0;
         branch   <= 2'b00;
         aluop    <= 2'b00;
         aluctl   <= 4'b0000;
         result   <= 32'd0;
         zero     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         regdst   <= c_regdst;
         alusrc   <= c_alusrc;
         memread  <= c_memread;
         memwrite <= c_memwrite;
         memtoreg <= c_memtoreg;
         regwrite <= c_regwrite;
         branch   <= c_branch;
         aluop    <= c_aluop;
         aluctl   <= c_aluctl;
         result   <= c_result;
         zero     <= (c_result == 32'd0);
         overflow <= c_overflow;
      end
   end

endmodule

// File: tb/tb_mips_decode_execute.sv
module tb_mips_decode_execute;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst, bubble;
   logic [31:0] instr, rs_data, rt_data;
   logic        regdst, alusrc, memread, memwrite, memtoreg, regwrite;
   logic [1:0]  branch, aluop;
   logic [3:0]  aluctl;
   logic [31:0] result;
   logic        zero, overflow;

   always #5 clk = ~clk;

   mips_decode_execute dut (
      .clk(clk), .rst(rst), .bubble(bubble), .instr(instr),
      .rs_data(rs_data), .rt_data(rt_data),
      .regdst(regdst), .alusrc(alusrc), .memread(memread), .memwrite(memwrite),
      .memtoreg(memtoreg), .regwrite(regwrite), .branch(branch), .aluop(aluop),
      .aluctl(aluctl), .result(result), .zero(zero), .overflow(overflow)
   );

   // packed view: regdst alusrc memread memwrite memtoreg regwrite branch aluop aluctl result zero overflow
   logic [47:0] dut_v;
   assign dut_v = {regdst, alusrc, memread, memwrite, memtoreg, regwrite,
                   branch, aluop, aluctl, result, zero, overflow};

   int n_tests = 0;
   int n_fail  = 0;
   logic [47:0] exp_q[$];
   logic [47:0] got_v;

   // ---------------- reference model ----------------
   function automatic logic [47:0] model(input logic [31:0] ins, input logic [31:0] a,
                                         input logic [31:0] b);
      // fields in table order: regdst alusrc memtoreg regwrite memread memwrite branch aluop
      logic [9:0]  c;
      logic [31:0] bv, r;
      logic [3:0]  code;
      longint      la, lb, s;
      logic        ov;
      int          op;  // 0 add 1 sub 2 and 3 or 4 xor 5 nor 6 slt
      case (ins[31:26])
         6'b000000: c = 10'b1_0_0_1_0_0_00_10;
         6'b100011: c = 10'b0_1_1_1_1_0_00_00;
         6'b101011: c = 10'b0_1_0_0_0_1_00_00;
         6'b000100: c = 10'b0_0_0_0_0_0_01_01;
         6'b000101: c = 10'b0_0_0_0_0_0_10_01;
         6'b001000: c = 10'b0_1_0_1_0_0_00_00;
         default:   c = 10'd0;
      endcase
      op = 0;
      if (c[1:0] == 2'b01) op = 1;
      else if (c[1:0] == 2'b10) begin
         case (ins[5:0])
            6'h22: op = 1;
            6'h24: op = 2;
            6'h25: op = 3;
            6'h26: op = 4;
            6'h27: op = 5;
            6'h2a: op = 6;
            default: op = 0;
         endcase
      end
      bv = c[8] ? 32'($signed(ins[15:0])) : b;
      la = longint'($signed(a));
      lb = longint'($signed(bv));
      ov = 1'b0;
      r  = 32'd0;
      case (op)
         0: begin s = la + lb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); code = 4'b0010; end
         1: begin s = la - lb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); code = 4'b0110; end
         2: begin r = a & bv;     code = 4'b0000; end
         3: begin r = a | bv;     code = 4'b0001; end
         4: begin r = a ^ bv;     code = 4'b1101; end
         5: begin r = ~(a | bv);  code = 4'b1100; end
         default: begin r = (la < lb) ? 32'd1 : 32'd0; code = 4'b0111; end
      endcase
      // repack: regdst alusrc memread memwrite memtoreg regwrite branch aluop
      return {c[9], c[8], c[5], c[4], c[7], c[6], c[3:2], c[1:0], code, r, (r == 32'd0), ov};
   endfunction

   function automatic logic [31:0] rt(input logic [5:0] f);
      return {6'b000000, 20'd0, f};
   endfunction

   function automatic logic [31:0] it(input logic [5:0] op, input logic [15:0] imm);
      return {op, 10'd0, imm};
   endfunction

   // ---------------- scoreboard check ----------------
   task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // One instruction per cycle: drive on the falling edge, check 1 ns after
   // the rising edge that captured it.
   task automatic drive(input string name, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic bub, input logic rs);
      @(negedge clk);
      instr = ins; rs_data = a; rt_data = b; bubble = bub; rst = rs;
      exp_q.push_back((rs || bub) ? 48'd0 : model(ins, a, b));
      @(posedge clk);
      #1;
      got_v = dut_v;
      check(name, got_v, exp_q.pop_front());
   endtask

   typedef struct {
      string       name;
      logic [31:0] ins, a, b, res;
      logic [3:0]  ctl;
      logic        z, ov;
   } vec_t;

   vec_t tbl[18];

   initial begin
      rst = 1'b1; bubble = 1'b0; instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;

      tbl[0]  = '{"and",     rt(6'h24), 32'h0000000F, 32'h000000F0, 32'h00000000, 4'b0000, 1'b1, 1'b0};
      tbl[1]  = '{"or",      rt(6'h25), 32'h0000000F, 32'h000000F0, 32'h000000FF, 4'b0001, 1'b0, 1'b0};
      tbl[2]  = '{"xor",     rt(6'h26), 32'h0000000F, 32'h000000F0, 32'h000000FF, 4'b1101, 1'b0, 1'b0};
      tbl[3]  = '{"nor",     rt(6'h27), 32'h0000000F, 32'h000000F0, 32'hFFFFFF00, 4'b1100, 1'b0, 1'b0};
      tbl[4]  = '{"sub",     rt(6'h22), 32'h0000000F, 32'h000000F0, 32'hFFFFFF1F, 4'b0110, 1'b0, 1'b0};
      tbl[5]  = '{"add",     rt(6'h20), 32'h0000000F, 32'h000000F0, 32'h000000FF, 4'b0010, 1'b0, 1'b0};
      tbl[6]  = '{"slt_m1",  rt(6'h2a), 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0111, 1'b0, 1'b0};
      tbl[7]  = '{"slt_p1",  rt(6'h2a), 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b0111, 1'b1, 1'b0};
      tbl[8]  = '{"lw",      it(6'b100011, 16'hFFFC), 32'h100, 32'hDEAD, 32'h000000FC, 4'b0010, 1'b0, 1'b0};
      tbl[9]  = '{"sw",      it(6'b101011, 16'hFFFC), 32'h100, 32'hDEAD, 32'h000000FC, 4'b0010, 1'b0, 1'b0};
      tbl[10] = '{"addi",    it(6'b001000, 16'hFFFC), 32'h100, 32'hDEAD, 32'h000000FC, 4'b0010, 1'b0, 1'b0};
      tbl[11] = '{"beq",     it(6'b000100, 16'h0010), 32'h1234, 32'h1234, 32'h00000000, 4'b0110, 1'b1, 1'b0};
      tbl[12] = '{"bne",     it(6'b000101, 16'h0010), 32'h1, 32'h2, 32'hFFFFFFFF, 4'b0110, 1'b0, 1'b0};
      tbl[13] = '{"add_ovf", rt(6'h20), 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b0010, 1'b0, 1'b1};
      tbl[14] = '{"sub_ovf", rt(6'h22), 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0110, 1'b0, 1'b1};
      tbl[15] = '{"add_1_1", rt(6'h20), 32'h1, 32'h1, 32'h00000002, 4'b0010, 1'b0, 1'b0};
      tbl[16] = '{"unk_op",  it(6'b111111, 16'h0000), 32'h3, 32'h4, 32'h00000007, 4'b0010, 1'b0, 1'b0};
      tbl[17] = '{"unk_fn",  rt(6'h00), 32'h2, 32'h3, 32'h00000005, 4'b0010, 1'b0, 1'b0};

      // ---- reset sequence ----
      drive("reset_all_zero", rt(6'h20), 32'd5, 32'd7, 1'b0, 1'b1);
      check("reset_zero_flag", {47'd0, zero}, 48'd0);
      drive("after_reset", rt(6'h20), 32'd5, 32'd7, 1'b0, 1'b0);
      check("after_reset_result", {16'd0, result}, 48'd12);
      check("after_reset_aluctl", {44'd0, aluctl}, 48'b0010);
      check("after_reset_regdst_regwrite", {46'd0, regdst, regwrite}, 48'b11);

      // ---- table ----
      foreach (tbl[i]) begin
         drive(tbl[i].name, tbl[i].ins, tbl[i].a, tbl[i].b, 1'b0, 1'b0);
         check({tbl[i].name, "_result"}, {16'd0, result}, {16'd0, tbl[i].res});
         check({tbl[i].name, "_aluctl_z_ov"}, {42'd0, aluctl, zero, overflow},
               {42'd0, tbl[i].ctl, tbl[i].z, tbl[i].ov});
         if (tbl[i].name == "lw")
            check("lw_ctl", {43'd0, alusrc, memread, memtoreg, regwrite, memwrite}, 48'b11110);
         if (tbl[i].name == "sw")
            check("sw_ctl", {45'd0, alusrc, memwrite, regwrite}, 48'b110);
         if (tbl[i].name == "addi")
            check("addi_ctl", {45'd0, alusrc, regwrite, regdst}, 48'b110);
         if (tbl[i].name == "beq")
            check("beq_branch", {46'd0, branch}, 48'b01);
         if (tbl[i].name == "bne")
            check("bne_branch", {46'd0, branch}, 48'b10);
         if (tbl[i].name == "unk_op")
            check("unk_op_ctl", {38'd0, regdst, alusrc, memread, memwrite, memtoreg, regwrite, branch, aluop}, 48'd0);
      end

      // ---- bubble sequence: valid instruction, bubble, valid again ----
      drive("pre_bubble", rt(6'h25), 32'hF0F0, 32'h0F0F, 1'b0, 1'b0);
      drive("bubble_add", rt(6'h20), 32'd5, 32'd7, 1'b1, 1'b0);
      check("bubble_zero_flag", {47'd0, zero}, 48'd0);
      drive("post_bubble", rt(6'h20), 32'd5, 32'd7, 1'b0, 1'b0);
      check("post_bubble_result", {16'd0, result}, 48'd12);
      drive("bubble_and_rst", rt(6'h20), 32'd5, 32'd7, 1'b1, 1'b1);

      // ---- randomized back-to-back stream ----
      for (int n = 0; n < 400; n++) begin
         logic [5:0]  ops[7];
         logic [5:0]  fns[8];
         logic [5:0]  op, fn;
         logic [31:0] a, b, ins;
         logic        bub, rs;
         ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b111111};
         fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h00};
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
         fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
         case ($urandom_range(0, 4))
            0: a = 32'h7FFFFFFF;
            1: a = 32'h80000000;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0: b = a;
            1: b = 32'hFFFFFFFF;
            default: b = $urandom;
         endcase
         ins = {op, 10'($urandom), 10'($urandom), fn};
         bub = ($urandom_range(0, 15) == 0);
         rs  = ($urandom_range(0, 31) == 0);
         drive("random", ins, a, b, bub, rs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
